// File: rtl/m65c02a_intc_pkg.sv
// Shared definitions for the M65C02A interrupt controller: register page addresses and service FSM states.
package m65c02a_intc_pkg;

  localparam logic [1:0] INTC_IER = 2'd0;
  localparam logic [1:0] INTC_EDG = 2'd1;
  localparam logic [1:0] INTC_IPR = 2'd2;
  localparam logic [1:0] INTC_VEC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } intcState_t;

endpackage

// File: rtl/m65c02a_intc_penc.sv
// Lowest-index-wins priority encoder (source 0 highest); purely combinational, 0 cycles.
// No flow control: Win is only meaningful while Any is high.
module m65c02a_intc_penc #(
  parameter int pNumSrc = 8
) (
  input  logic [pNumSrc-1:0] Act,
  output logic [2:0]         Win,
  output logic               Any
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    Win = 3'd0;
    for (int i = pNumSrc - 1; i >= 0; i--) begin
      if (Act[i]) Win = 3'(i);
    end
  end

  assign Any = |Act;

endmodule

// File: rtl/m65c02a_intc.sv
// 8-source maskable IRQ controller driving M65C02A nIRQ; IntSrc->nIRQ 1 cycle level / 2 edge, +2 with M65C02A_INTC_SYNC_EN.
// No backpressure: register reads land in DO the cycle after Sel&RE; requests stay pending until acked or cleared.
module m65c02a_intc
  import m65c02a_intc_pkg::*;
#(
  parameter int   pNumSrc   = 8,
  parameter logic pLvlReset = 1'b0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Sel,
  input  logic               WE,
  input  logic               RE,
  input  logic [1:0]         Addr,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic [pNumSrc-1:0] IntSrc,
  output logic               nIRQ,
  output logic               InSvc
);

  logic [pNumSrc-1:0] src, srcD, ier, edg, edgeLat, ipr, act;
  logic [pNumSrc-1:0] w1c, ackClr, setMask;
  logic [2:0]         win, vecIdx;
  logic               any, regWr, regRd, vecRd, eoi, ack, nIrqNxt;
  logic [7:0]         vecVal, rdMux;
  intcState_t         state, stateNxt;

`ifdef M65C02A_INTC_SYNC_EN
  logic [pNumSrc-1:0] syncA, syncB;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= IntSrc;
      syncB <= syncA;
    end
  end

  assign src = syncB;
`else
  assign src = IntSrc;
`endif

  assign regWr = Sel & WE;
  assign regRd = Sel & RE;
  assign vecRd = regRd & (Addr == INTC_VEC);
  assign eoi   = regWr & (Addr == INTC_VEC);

  // Edge-mode bits show the sticky latch, level-mode bits follow the source live.
  assign ipr = (edg & edgeLat) | (~edg & src);
  assign act = ipr & ier;

  m65c02a_intc_penc #(.pNumSrc(pNumSrc)) u_penc (
    .Act (act),
    .Win (win),
    .Any (any)
  );

  always_comb begin
    stateNxt = state;
    nIrqNxt  = nIRQ;
    ack      = 1'b0;
    case (state)
      IDLE: begin
        nIrqNxt = ~any;
        if (any) stateNxt = REQ;
      end
      REQ: begin
        if (vecRd && any) begin
          stateNxt = SVC;
          nIrqNxt  = 1'b1;
          ack      = 1'b1;
        end else if (!any) begin
          stateNxt = IDLE;
          nIrqNxt  = 1'b1;
        end else begin
          nIrqNxt  = 1'b0;
        end
      end
      SVC: begin
        nIrqNxt = 1'b1;
        if (eoi) stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
        nIrqNxt  = 1'b1;
      end
    endcase
  end

  always_comb begin
    ackClr = '0;
    if (ack) ackClr[win] = 1'b1;
  end

  assign w1c     = (regWr && (Addr == INTC_IPR)) ? DI[pNumSrc-1:0] : '0;
  assign setMask = edg & src & ~srcD;

  // While in service the vector register reports the acknowledged source, not the current winner.
  assign vecVal = (state == SVC) ? {1'b1, 4'b0000, vecIdx} : {any, 4'b0000, win};

  always_comb begin
    rdMux = 8'h00;
    case (Addr)
      INTC_IER: rdMux = 8'(ier);
      INTC_EDG: rdMux = 8'(edg);
      INTC_IPR: rdMux = 8'(ipr);
      INTC_VEC: rdMux = vecVal;
      default:  rdMux = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ier     <= '0;
      edg     <= {pNumSrc{pLvlReset}};
      edgeLat <= '0;
      srcD    <= '0;
      DO      <= 8'h00;
      nIRQ    <= 1'b1;
      state   <= IDLE;
      vecIdx  <= 3'd0;
    end else begin
      srcD    <= src;
      // A new edge in the same cycle as a clear keeps the request pending.
      edgeLat <= (edgeLat & ~(w1c | ackClr)) | setMask;
      nIRQ    <= nIrqNxt;
      state   <= stateNxt;
      if (regWr && (Addr == INTC_IER)) ier <= DI[pNumSrc-1:0];
      if (regWr && (Addr == INTC_EDG)) edg <= DI[pNumSrc-1:0];
      if (regRd) DO <= rdMux;
      if (ack) vecIdx <= win;
    end
  end

  assign InSvc = (state == SVC);

endmodule
